// File: rtl/lcd_pkg.sv
// lcd_pkg: register addresses, CTRL bit positions and FSM state codes for the LCD reset sequencer
package lcd_pkg;
    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_LOW   = 2'd1;
    localparam logic [1:0] ADDR_WAIT  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_IRQ_EN   = 2;
    localparam int CTRL_DONE_CLR = 3;
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_RECOVER = 2'd2
    } state_t;
endpackage

// File: rtl/lcd_rst_seq_if.sv
// lcd_rst_seq_if: Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata)
interface lcd_rst_seq_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lcd_rst_timer.sv
// lcd_rst_timer: loadable down-counter; load wins over dec, dec stops at zero so it never wraps
module lcd_rst_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        value = cnt_q;
        zero  = cnt_q == '0;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/lcd_rst_seq.sv
// lcd_rst_seq: Avalon-MM sequencer that pulses lcd_rst_n low for LOW cycles, waits WAIT cycles, then flags done/irq
// ports: clk, reset (sync, active high), bus (slave), lcd_rst_n (registered), irq = done & irq_en
module lcd_rst_seq
    import lcd_pkg::*;
#(
    parameter int          CNT_W      = 24,
    parameter int unsigned DEF_LOW    = 50000,
    parameter int unsigned DEF_WAIT   = 6000000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    lcd_rst_seq_if.slave  bus,
    output logic          lcd_rst_n,
    output logic          irq
);
    state_t           state_q, state_d;
    logic             rst_n_q, rst_n_d, done_q, done_d, irq_en_q, irq_en_d, auto_q;
    logic [CNT_W-1:0] low_q, low_d, wait_q, wait_d;
    logic             wr, ctrl_wr, abort, go, load, zero;
    logic [CNT_W-1:0] load_val, count;

    // a phase of length max(x,1) needs the counter loaded with max(x,1)-1
    function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] x);
        return (x == '0) ? '0 : x - CNT_W'(1);
    endfunction

    lcd_rst_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .dec      (state_q != S_IDLE),
        .load_val (load_val),
        .value    (count),
        .zero     (zero)
    );

    always_comb begin
        wr       = bus.chipselect && !bus.write_n;
        ctrl_wr  = wr && bus.address == ADDR_CTRL;
        abort    = ctrl_wr && bus.writedata[CTRL_ABORT];
        // auto_q is high only on the first cycle after reset when AUTO_START is set
        go       = state_q == S_IDLE && !abort && (auto_q || (ctrl_wr && bus.writedata[CTRL_START]));
        low_d    = (wr && bus.address == ADDR_LOW)  ? bus.writedata[CNT_W-1:0] : low_q;
        wait_d   = (wr && bus.address == ADDR_WAIT) ? bus.writedata[CNT_W-1:0] : wait_q;
        irq_en_d = ctrl_wr ? bus.writedata[CTRL_IRQ_EN] : irq_en_q;
        done_d   = (ctrl_wr && bus.writedata[CTRL_DONE_CLR]) ? 1'b0 : done_q;
        state_d  = state_q;
        rst_n_d  = rst_n_q;
        load     = 1'b0;
        load_val = '0;
        if (abort) begin
            state_d = S_IDLE;
            rst_n_d = 1'b1;
            load    = 1'b1;
        end else if (go) begin
            state_d  = S_ASSERT;
            rst_n_d  = 1'b0;
            load     = 1'b1;
            load_val = phase_len(low_q);
            done_d   = 1'b0;
        end else if (zero && state_q == S_ASSERT) begin
            state_d  = S_RECOVER;
            rst_n_d  = 1'b1;
            load     = 1'b1;
            load_val = phase_len(wait_q);
        end else if (zero && state_q == S_RECOVER) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rst_n_q  <= 1'b1;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            low_q    <= CNT_W'(DEF_LOW);
            wait_q   <= CNT_W'(DEF_WAIT);
            auto_q   <= AUTO_START;
        end else begin
            state_q  <= state_d;
            rst_n_q  <= rst_n_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            low_q    <= low_d;
            wait_q   <= wait_d;
            auto_q   <= 1'b0;
        end
    end

    always_comb begin
        bus.readdata = (bus.address == ADDR_CTRL) ? {26'd0, state_q, rst_n_q, irq_en_q, done_q, state_q != S_IDLE} :
                       (bus.address == ADDR_LOW)  ? 32'(low_q) :
                       (bus.address == ADDR_WAIT) ? 32'(wait_q) : 32'(count);
        lcd_rst_n    = rst_n_q;
        irq          = done_q && irq_en_q;
    end
endmodule

// File: tb/tb_lcd_rst_seq.sv
// tb_lcd_rst_seq: directed checks of the LCD reset sequencer with and without auto-start
module tb_lcd_rst_seq;
    import lcd_pkg::*;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic rst_n_a, irq_a, rst_n_b, irq_b;
    int tests_run = 0, failed = 0;

    always #5 clk = ~clk;

    lcd_rst_seq_if bus_a();
    lcd_rst_seq_if bus_b();

    lcd_rst_seq #(.CNT_W(24), .DEF_LOW(4), .DEF_WAIT(3), .AUTO_START(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a), .lcd_rst_n(rst_n_a), .irq(irq_a));
    lcd_rst_seq #(.CNT_W(24), .DEF_LOW(4), .DEF_WAIT(3), .AUTO_START(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b), .lcd_rst_n(rst_n_b), .irq(irq_b));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit a, input logic [1:0] addr, input logic [31:0] d);
        if (a) begin
            bus_a.address = addr; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0; bus_a.writedata = d;
        end else begin
            bus_b.address = addr; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; bus_b.writedata = d;
        end
        step;
        bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.address = ADDR_CTRL;
        bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.address = ADDR_CTRL;
        #1;
    endtask

    task automatic rd(input bit a, input logic [1:0] addr, output logic [31:0] d);
        if (a) bus_a.address = addr; else bus_b.address = addr;
        #1;
        d = a ? bus_a.readdata : bus_b.readdata;
        bus_a.address = ADDR_CTRL;
        bus_b.address = ADDR_CTRL;
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        step; step;
        tests_run++; if (rst_n_a !== 1'b1) begin failed++; $display("FAIL reset_rst_n_a got %b exp 1", rst_n_a); end
        tests_run++; if (irq_a !== 1'b0) begin failed++; $display("FAIL reset_irq_a got %b exp 0", irq_a); end
        tests_run++; if (bus_a.readdata !== 32'h08) begin failed++; $display("FAIL reset_ctrl_a got %h exp 08", bus_a.readdata); end
        rd(1'b1, ADDR_COUNT, d);
        tests_run++; if (d !== 32'd0) begin failed++; $display("FAIL reset_count got %0d exp 0", d); end
        rd(1'b1, ADDR_LOW, d);
        tests_run++; if (d !== 32'd4) begin failed++; $display("FAIL reset_low got %0d exp 4", d); end
        rd(1'b1, ADDR_WAIT, d);
        tests_run++; if (d !== 32'd3) begin failed++; $display("FAIL reset_wait got %0d exp 3", d); end
        rst_b = 1'b0;
        step; step;
        tests_run++; if (bus_b.readdata !== 32'h08) begin failed++; $display("FAIL no_auto_ctrl got %h exp 08", bus_b.readdata); end
        tests_run++; if (rst_n_b !== 1'b1) begin failed++; $display("FAIL no_auto_rst_n got %b exp 1", rst_n_b); end
    endtask

    task automatic test_auto_start;
        logic [31:0] exp_ctrl;
        rst_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step;
            exp_ctrl = (i < 4) ? 32'h11 : (i < 7) ? 32'h29 : 32'h0A;
            tests_run++; if (bus_a.readdata !== exp_ctrl) begin failed++; $display("FAIL auto_ctrl[%0d] got %h exp %h", i, bus_a.readdata, exp_ctrl); end
            tests_run++; if (rst_n_a !== (i >= 4)) begin failed++; $display("FAIL auto_rst_n[%0d] got %b exp %b", i, rst_n_a, i >= 4); end
        end
    endtask

    task automatic test_min;
        logic [31:0] d;
        wr(1'b0, ADDR_LOW, 32'd0);
        wr(1'b0, ADDR_WAIT, 32'd0);
        wr(1'b0, ADDR_CTRL, 32'h1);
        tests_run++; if (bus_b.readdata !== 32'h11 || rst_n_b !== 1'b0) begin failed++; $display("FAIL min_assert got %h/%b exp 11/0", bus_b.readdata, rst_n_b); end
        step;
        tests_run++; if (bus_b.readdata !== 32'h29 || rst_n_b !== 1'b1) begin failed++; $display("FAIL min_recover got %h/%b exp 29/1", bus_b.readdata, rst_n_b); end
        step;
        tests_run++; if (bus_b.readdata !== 32'h0A) begin failed++; $display("FAIL min_done got %h exp 0A", bus_b.readdata); end
        wr(1'b0, ADDR_COUNT, 32'd5);
        rd(1'b0, ADDR_COUNT, d);
        tests_run++; if (d !== 32'd0) begin failed++; $display("FAIL count_ro got %0d exp 0", d); end
    endtask

    task automatic test_irq;
        wr(1'b0, ADDR_LOW, 32'd10);
        wr(1'b0, ADDR_WAIT, 32'd5);
        wr(1'b0, ADDR_CTRL, 32'h5);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step;
            tests_run++; if (rst_n_b !== (i >= 10)) begin failed++; $display("FAIL irq_rst_n[%0d] got %b exp %b", i, rst_n_b, i >= 10); end
            tests_run++; if (irq_b !== (i == 15)) begin failed++; $display("FAIL irq[%0d] got %b exp %b", i, irq_b, i == 15); end
        end
        wr(1'b0, ADDR_CTRL, 32'hC);
        tests_run++; if (irq_b !== 1'b0) begin failed++; $display("FAIL irq_clr got %b exp 0", irq_b); end
        tests_run++; if (bus_b.readdata !== 32'h0C) begin failed++; $display("FAIL done_clr_ctrl got %h exp 0C", bus_b.readdata); end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        wr(1'b0, ADDR_CTRL, 32'h1);
        step; step; step;
        rd(1'b0, ADDR_COUNT, d);
        tests_run++; if (d !== 32'd6) begin failed++; $display("FAIL abort_pre_count got %0d exp 6", d); end
        wr(1'b0, ADDR_CTRL, 32'h3);
        tests_run++; if (bus_b.readdata !== 32'h08) begin failed++; $display("FAIL abort_ctrl got %h exp 08", bus_b.readdata); end
        tests_run++; if (rst_n_b !== 1'b1) begin failed++; $display("FAIL abort_rst_n got %b exp 1", rst_n_b); end
        rd(1'b0, ADDR_COUNT, d);
        tests_run++; if (d !== 32'd0) begin failed++; $display("FAIL abort_count got %0d exp 0", d); end
        step;
        tests_run++; if (bus_b.readdata !== 32'h08) begin failed++; $display("FAIL abort_stay_idle got %h exp 08", bus_b.readdata); end
    endtask

    task automatic test_busy_start;
        logic [31:0] d;
        wr(1'b0, ADDR_CTRL, 32'h1);
        for (int i = 0; i < 11; i++) step;
        tests_run++; if (bus_b.readdata !== 32'h29) begin failed++; $display("FAIL busy_in_recover got %h exp 29", bus_b.readdata); end
        wr(1'b0, ADDR_LOW, 32'd2);
        wr(1'b0, ADDR_CTRL, 32'h1);
        tests_run++; if (bus_b.readdata !== 32'h29) begin failed++; $display("FAIL busy_start_ignored got %h exp 29", bus_b.readdata); end
        rd(1'b0, ADDR_COUNT, d);
        tests_run++; if (d !== 32'd1) begin failed++; $display("FAIL busy_count got %0d exp 1", d); end
        step;
        tests_run++; if (bus_b.readdata !== 32'h29) begin failed++; $display("FAIL busy_last_recover got %h exp 29", bus_b.readdata); end
        step;
        tests_run++; if (bus_b.readdata !== 32'h0A) begin failed++; $display("FAIL busy_done got %h exp 0A", bus_b.readdata); end
        for (int j = 0; j < 8; j++) begin
            if (j == 0) wr(1'b0, ADDR_CTRL, 32'h1); else step;
            if (j < 3) begin
                tests_run++; if (rst_n_b !== (j >= 2)) begin failed++; $display("FAIL pulse2_rst_n[%0d] got %b exp %b", j, rst_n_b, j >= 2); end
            end
        end
        tests_run++; if (bus_b.readdata !== 32'h0A) begin failed++; $display("FAIL pulse2_done got %h exp 0A", bus_b.readdata); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(1'b1, ADDR_CTRL, 32'h1);
        tests_run++; if (rst_n_a !== 1'b0) begin failed++; $display("FAIL mid_start got %b exp 0", rst_n_a); end
        step;
        rst_a = 1'b1;
        step;
        tests_run++; if (rst_n_a !== 1'b1) begin failed++; $display("FAIL mid_reset_rst_n got %b exp 1", rst_n_a); end
        tests_run++; if (bus_a.readdata !== 32'h08) begin failed++; $display("FAIL mid_reset_ctrl got %h exp 08", bus_a.readdata); end
        rst_a = 1'b0;
        step;
        tests_run++; if (rst_n_a !== 1'b0) begin failed++; $display("FAIL mid_restart_rst_n got %b exp 0", rst_n_a); end
        tests_run++; if (bus_a.readdata !== 32'h11) begin failed++; $display("FAIL mid_restart_ctrl got %h exp 11", bus_a.readdata); end
        rd(1'b1, ADDR_COUNT, d);
        tests_run++; if (d !== 32'd3) begin failed++; $display("FAIL mid_restart_count got %0d exp 3", d); end
    endtask

    initial begin
        bus_a.address = ADDR_CTRL; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
        bus_b.address = ADDR_CTRL; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
        test_reset;
        test_auto_start;
        test_min;
        test_irq;
        test_abort;
        test_busy_start;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
